// File: rtl/muldiv_pkg.sv
// RV32M multiply/divide shared definitions: widths, funct3 codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: XLEN/ITER constants, MD_MUL..MD_REMU codes, IDLE/CALC/DONE state
// encoding, the signed-overflow dividend pattern and a conditional-negate helper.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Most negative dividend; DIV by -1 of this value overflows.
    localparam logic [XLEN-1:0] OVF_PATTERN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Two's-complement negate when n is set.
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing pipeline and the muldiv unit.
// Latency: n/a (wires only).
// Backpressure: requester must hold off while MD_busy is high; starts then are dropped.
// master = pipeline side (drives start/operands), slave = muldiv unit side.
interface muldiv_if;

    logic                          MD_start;
    logic [2:0]                    MD_funct3;
    logic [muldiv_pkg::XLEN-1:0]   MD_rs1_data;
    logic [muldiv_pkg::XLEN-1:0]   MD_rs2_data;
    logic [4:0]                    MD_rd;

    logic                          MD_busy;
    logic                          MD_done;
    logic [muldiv_pkg::XLEN-1:0]   MD_result;
    logic [4:0]                    MD_rd_out;
    logic                          MD_write_enable;

    modport master (
        output MD_start, MD_funct3, MD_rs1_data, MD_rs2_data, MD_rd,
        input  MD_busy, MD_done, MD_result, MD_rd_out, MD_write_enable
    );

    modport slave (
        input  MD_start, MD_funct3, MD_rs1_data, MD_rs2_data, MD_rd,
        output MD_busy, MD_done, MD_result, MD_rd_out, MD_write_enable
    );

endinterface

// File: rtl/muldiv_shift_core.sv
// Unsigned radix-2 datapath: shift-add multiply / restoring shift-subtract divide.
// Latency: one iteration per step_i; 32 steps give the full result.
// Backpressure: none; the caller sequences load_i/step_i.
// Ports: clk_i, rst_i (sync, active-high), load_i, step_i, is_div_i, a_i
// (multiplicand/dividend), b_i (multiplier/divisor), hi_o/lo_o (product
// high/low, or remainder/quotient). Divide logic exists only with MULDIV_DIV_EN.
module muldiv_shift_core
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN:0]   add_sum;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
`else
    logic            unused_is_div;
    assign unused_is_div = is_div_i;
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        m_d  = m_q;
        // Multiply: conditionally add the multiplicand into the high half,
        // keeping the carry so the right shift loses nothing.
        add_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, m_q}) : {1'b0, hi_q};
`ifdef MULDIV_DIV_EN
        // Divide: partial remainder gains the next dividend bit; a clear
        // borrow bit means the divisor fits and the quotient bit is 1.
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, m_q};
`endif
        if (load_i) begin
            hi_d = '0;
`ifdef MULDIV_DIV_EN
            if (is_div_i) begin
                lo_d = a_i;
                m_d  = b_i;
            end else begin
                lo_d = b_i;
                m_d  = a_i;
            end
`else
            lo_d = b_i;
            m_d  = a_i;
`endif
        end else if (step_i) begin
`ifdef MULDIV_DIV_EN
            if (is_div_i) begin
                if (diff[XLEN]) begin
                    hi_d = shifted[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end else begin
                    hi_d = diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end
            end else begin
                {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
            end
`else
            {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q  <= m_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, fast path, outputs.
// Latency: MD_done 33 cycles after an accepted start, 1 cycle on the fast path.
// Backpressure: MD_busy high in CALC/DONE; starts seen while busy are dropped.
// Ports: SYS_clk, SYS_reset (sync, active-high), md (muldiv_if.slave).
// Optional MULDIV_DIV_EN: present = DIV/DIVU/REM/REMU supported; absent = those
// codes complete on the fast path with result 0 and no register write.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    SYS_clk,
    input  logic    SYS_reset,
    muldiv_if.slave md
);

    md_state_e       state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            load, step, done_d;

    logic [2:0]      f3_q;
    logic            neg_a_q, neg_b_q, fast_q, legal_q;
    logic [XLEN-1:0] fast_res_q, result_q;
    logic [4:0]      rd_q;
    logic            done_q, we_q;

    // Start-edge decode of the live operands.
    logic [2:0]      f3;
    logic [XLEN-1:0] opa, opb, mag_a, mag_b, fast_val;
    logic            sgn_a, sgn_b, neg_a, neg_b, fast, legal;

    assign f3  = md.MD_funct3;
    assign opa = md.MD_rs1_data;
    assign opb = md.MD_rs2_data;

    // MUL only needs the low product half, which is sign-agnostic.
    assign sgn_a = (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    assign sgn_b = (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    assign neg_a = sgn_a & opa[XLEN-1];
    assign neg_b = sgn_b & opb[XLEN-1];
    assign mag_a = neg_if(neg_a, opa);
    assign mag_b = neg_if(neg_b, opb);

`ifdef MULDIV_DIV_EN
    logic div_zero, div_ovf;
    assign div_zero = f3[2] & (opb == '0);
    assign div_ovf  = ((f3 == MD_DIV) || (f3 == MD_REM)) & (opa == OVF_PATTERN) & (opb == '1);
    assign fast     = div_zero | div_ovf;
    assign legal    = 1'b1;
    // f3[1] separates REM/REMU from DIV/DIVU.
    assign fast_val = div_zero ? (f3[1] ? opa : '1)
                               : (f3[1] ? '0  : OVF_PATTERN);
`else
    assign fast     = f3[2];
    assign legal    = ~f3[2];
    assign fast_val = '0;
`endif

    logic [XLEN-1:0] core_hi, core_lo;
    logic            core_is_div;

    // The operation kind comes from the live funct3 while loading and from the
    // latched copy while iterating.
    assign core_is_div = (state_q == ST_IDLE) ? f3[2] : f3_q[2];

    muldiv_shift_core u_core (
        .clk_i    (SYS_clk),
        .rst_i    (SYS_reset),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (core_is_div),
        .a_i      (mag_a),
        .b_i      (mag_b),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    // Sign restoration on the unsigned core result.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   calc_res;

    assign prod   = {core_hi, core_lo};
    assign prod_s = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;

    always_comb begin
        calc_res = '0;
        case (f3_q)
            MD_MUL:                          calc_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:    calc_res = prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            MD_DIV:                          calc_res = neg_if(neg_a_q ^ neg_b_q, core_lo);
            MD_DIVU:                         calc_res = core_lo;
            MD_REM:                          calc_res = neg_if(neg_a_q, core_hi);
            MD_REMU:                         calc_res = core_hi;
`endif
            default:                         calc_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state and datapath strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md.MD_start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation context and registered outputs.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            f3_q       <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            fast_q     <= 1'b0;
            legal_q    <= 1'b0;
            fast_res_q <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && md.MD_start) begin
                f3_q       <= f3;
                neg_a_q    <= neg_a;
                neg_b_q    <= neg_b;
                fast_q     <= fast;
                legal_q    <= legal;
                fast_res_q <= fast_val;
                rd_q       <= md.MD_rd;
            end
            done_q <= done_d;
            we_q   <= done_d & legal_q;
            if (done_d) begin
                result_q <= fast_q ? fast_res_q : calc_res;
            end
        end
    end

    assign md.MD_busy         = (state_q != ST_IDLE);
    assign md.MD_done         = done_q;
    assign md.MD_result       = result_q;
    assign md.MD_rd_out       = rd_q;
    assign md.MD_write_enable = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus start-spacing, fast-path and reset sequences.
// Latency: checks done at 33 cycles (1 on fast path) after the start edge.
// Backpressure: checks that starts while busy are dropped.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_if md_if ();

    muldiv_unit dut (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .md        (md_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    // Divide-class codes collapse to the fast "illegal" completion when the
    // divider is not built.
    function automatic void add_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rd, input logic [31:0] res, input int lat);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.rd = rd;
        v.exp_res = (f3[2] && !DIV_EN) ? 32'h0 : res;
        v.exp_lat = (f3[2] && !DIV_EN) ? 1 : lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
        md_if.MD_start    = 1'b1;
        md_if.MD_funct3   = f3;
        md_if.MD_rs1_data = a;
        md_if.MD_rs2_data = b;
        md_if.MD_rd       = rd;
    endtask

    // Scramble operands after the start edge; the unit must ignore them.
    task automatic scramble();
        md_if.MD_start    = 1'b0;
        md_if.MD_funct3   = 3'($urandom);
        md_if.MD_rs1_data = $urandom;
        md_if.MD_rs2_data = $urandom;
        md_if.MD_rd       = 5'($urandom);
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int   lat;
        logic exp_we;
        exp_we = DIV_EN ? 1'b1 : !v.f3[2];
        drive_start(v.f3, v.a, v.b, v.rd);
        @(posedge clk); #1;
        scramble();
        check($sformatf("v%0d_busy", idx), {31'b0, md_if.MD_busy}, 32'd1);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (md_if.MD_done) begin
                lat = k;
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_result", idx), md_if.MD_result, v.exp_res);
        check($sformatf("v%0d_we", idx), {31'b0, md_if.MD_write_enable}, {31'b0, exp_we});
        check($sformatf("v%0d_rd", idx), {27'b0, md_if.MD_rd_out}, {27'b0, v.rd});
        check($sformatf("v%0d_idle", idx), {31'b0, md_if.MD_busy}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_pulse", idx), {31'b0, md_if.MD_done}, 32'd0);
    endtask

    // Starts at E+5 and E+33 are dropped; the one at E+34 is taken.
    task automatic seq_ignore();
        int n = 0, d1 = -1, d2 = -1;
        logic [31:0] r1 = '0, r2 = '0;
        logic [4:0]  rd1 = '0, rd2 = '0;
        drive_start(MD_MUL, 32'd3, 32'd5, 5'd3);
        @(posedge clk); #1;
        scramble();
        for (int k = 1; k <= 75; k++) begin
            if (k == 5)       drive_start(MD_MUL, 32'd100, 32'd100, 5'd5);
            else if (k == 33) drive_start(MD_MUL, 32'd11, 32'd11, 5'd6);
            else if (k == 34) drive_start(MD_MUL, 32'd6, 32'd7, 5'd9);
            @(posedge clk); #1;
            md_if.MD_start = 1'b0;
            if (md_if.MD_done) begin
                n++;
                if (n == 1) begin d1 = k; r1 = md_if.MD_result; rd1 = md_if.MD_rd_out; end
                if (n == 2) begin d2 = k; r2 = md_if.MD_result; rd2 = md_if.MD_rd_out; end
            end
        end
        check("ign_done1_cycle", d1, 33);
        check("ign_result1", r1, 32'd15);
        check("ign_rd1", {27'b0, rd1}, 32'd3);
        check("ign_done2_cycle", d2, 67);
        check("ign_result2", r2, 32'd42);
        check("ign_rd2", {27'b0, rd2}, 32'd9);
        check("ign_done_count", n, 2);
    endtask

    // Back-to-back fast-path ops: start at E+1 dropped, E+2 taken.
    task automatic seq_fast();
        int n = 0, d1 = -1, d2 = -1;
        logic [31:0] r1 = '0, r2 = '0;
        logic [4:0]  rd2 = '0;
        drive_start(MD_DIV, 32'd5, 32'd0, 5'd2);
        @(posedge clk); #1;
        scramble();
        for (int k = 1; k <= 10; k++) begin
            if (k == 1)      drive_start(MD_DIVU, 32'd9, 32'd0, 5'd7);
            else if (k == 2) drive_start(MD_REMU, 32'd9, 32'd0, 5'd8);
            @(posedge clk); #1;
            md_if.MD_start = 1'b0;
            if (md_if.MD_done) begin
                n++;
                if (n == 1) begin d1 = k; r1 = md_if.MD_result; end
                if (n == 2) begin d2 = k; r2 = md_if.MD_result; rd2 = md_if.MD_rd_out; end
            end
        end
        check("fast_done1_cycle", d1, 1);
        check("fast_result1", r1, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
        check("fast_done2_cycle", d2, 3);
        check("fast_result2", r2, DIV_EN ? 32'd9 : 32'h0);
        check("fast_rd2", {27'b0, rd2}, 32'd8);
        check("fast_done_count", n, 2);
    endtask

    // Reset at E+10 aborts the operation without a completion.
    task automatic seq_reset();
        int n = 0;
        drive_start(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd4);
        @(posedge clk); #1;
        scramble();
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", {31'b0, md_if.MD_busy}, 32'd0);
        check("rst_done", {31'b0, md_if.MD_done}, 32'd0);
        check("rst_we", {31'b0, md_if.MD_write_enable}, 32'd0);
        check("rst_result", md_if.MD_result, 32'd0);
        check("rst_rd", {27'b0, md_if.MD_rd_out}, 32'd0);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_if.MD_done) n++;
        end
        check("rst_no_done", n, 0);
    endtask

    initial begin
        md_if.MD_start    = 1'b0;
        md_if.MD_funct3   = '0;
        md_if.MD_rs1_data = '0;
        md_if.MD_rs2_data = '0;
        md_if.MD_rd       = '0;

        add_vec(MD_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
        add_vec(MD_MUL,    32'h1234_5678, 32'h0000_0010, 5'd2,  32'h2345_6780, 33);
        add_vec(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
        add_vec(MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33);
        add_vec(MD_MULH,   32'h1234_5678, 32'h0000_0010, 5'd5,  32'h0000_0001, 33);
        add_vec(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33);
        add_vec(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 33);
        add_vec(MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 33);
        add_vec(MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
        add_vec(MD_DIV,    32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
        add_vec(MD_REM,    32'd7,         32'hFFFF_FFFE, 5'd11, 32'h0000_0001, 33);
        add_vec(MD_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        33);
        add_vec(MD_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         33);
        add_vec(MD_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF, 33);
        add_vec(MD_DIV,    32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1);
        add_vec(MD_REM,    32'd5,         32'd0,         5'd16, 32'd5,         1);
        add_vec(MD_DIVU,   32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1);
        add_vec(MD_REMU,   32'd9,         32'd0,         5'd18, 32'd9,         1);
        add_vec(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1);
        add_vec(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, 1);
        add_vec(MD_DIV,    32'd9,         32'd3,         5'd21, 32'd3,         33);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_busy", {31'b0, md_if.MD_busy}, 32'd0);
        check("reset_done", {31'b0, md_if.MD_done}, 32'd0);
        check("reset_we", {31'b0, md_if.MD_write_enable}, 32'd0);
        check("reset_result", md_if.MD_result, 32'd0);
        check("reset_rd", {27'b0, md_if.MD_rd_out}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i], i);

        seq_ignore();
        @(posedge clk); #1;
        seq_fast();
        @(posedge clk); #1;
        seq_reset();

        // Unit must work normally after an aborted operation.
        run_op(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
